// File: rtl/elevator_if.sv
// Request/status bundle between the elevator controller and its requester.
// The requester drives the strobe and floor; the controller drives everything else.
interface elevator_if #(
    parameter int NUM_FLOORS = 10,
    parameter int FLOOR_W    = 4
);
    logic                  req_valid;
    logic [FLOOR_W-1:0]    req_floor;
    logic [FLOOR_W-1:0]    current_floor;
    logic                  moving_up;
    logic                  moving_down;
    logic                  door_open;
    logic                  arrive;
    logic [NUM_FLOORS-1:0] pending;

    modport master (
        output req_valid, req_floor,
        input  current_floor, moving_up, moving_down, door_open, arrive, pending
    );

    modport slave (
        input  req_valid, req_floor,
        output current_floor, moving_up, moving_down, door_open, arrive, pending
    );
endinterface

// File: rtl/elevator_controller.sv
// Multi-floor elevator controller: latches requests into a pending bitmap and
// serves them with SCAN scheduling, timed door phase and an arrival pulse.
module elevator_controller #(
    parameter int NUM_FLOORS   = 10,
    parameter int FLOOR_W      = 4,
    parameter int TRAVEL_TICKS = 16,
    parameter int DOOR_TICKS   = 8
) (
    input  logic      clk,
    input  logic      reset,
    elevator_if.slave bus
);
    localparam int MAX_TICKS = (TRAVEL_TICKS > DOOR_TICKS) ? TRAVEL_TICKS : DOOR_TICKS;
    localparam int TIMER_W   = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
    localparam logic [TIMER_W-1:0] TRAVEL_LAST = TIMER_W'(TRAVEL_TICKS - 1);
    localparam logic [TIMER_W-1:0] DOOR_LAST   = TIMER_W'(DOOR_TICKS - 1);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);

    typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN} state_t;

    state_t                state_q,   state_d;
    logic [FLOOR_W-1:0]    floor_q,   floor_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic [TIMER_W-1:0]    timer_q,   timer_d;
    logic                  last_up_q, last_up_d;
    logic                  arrive_q,  arrive_d;

    logic [NUM_FLOORS-1:0] above_vec, below_vec, cur_onehot, req_vec;
    logic                  any_above, any_below, any_here, door_hit;

    // Per-floor decode; out-of-range request floors match no bit and are dropped.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_FLOORS; gi++) begin : g_floor
            assign above_vec[gi]  = pending_q[gi] && (gi > int'(floor_q));
            assign below_vec[gi]  = pending_q[gi] && (gi < int'(floor_q));
            assign cur_onehot[gi] = (int'(floor_q) == gi);
            assign req_vec[gi]    = bus.req_valid && (int'(bus.req_floor) == gi);
        end
    endgenerate

    assign any_above = |above_vec;
    assign any_below = |below_vec;
    assign any_here  = |(pending_q & cur_onehot);
    assign door_hit  = bus.req_valid && (bus.req_floor == floor_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            floor_q   <= '0;
            pending_q <= '0;
            timer_q   <= '0;
            last_up_q <= 1'b1;
            arrive_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            floor_q   <= floor_d;
            pending_q <= pending_d;
            timer_q   <= timer_d;
            last_up_q <= last_up_d;
            arrive_q  <= arrive_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        floor_d   = floor_q;
        timer_d   = timer_q;
        last_up_d = last_up_q;
        unique case (state_q)
            IDLE: begin
                timer_d = '0;
                if (any_here) begin
                    state_d = DOOR_OPEN;
                end else if (any_above && (last_up_q || !any_below)) begin
                    state_d   = MOVE_UP;
                    last_up_d = 1'b1;
                end else if (any_below) begin
                    state_d   = MOVE_DOWN;
                    last_up_d = 1'b0;
                end
            end
            // Timer value 0 is the evaluation cycle that follows every step.
            MOVE_UP: begin
                timer_d = timer_q + TIMER_W'(1);
                if (timer_q == '0 && any_here) begin
                    state_d = DOOR_OPEN;
                    timer_d = '0;
                end else if (timer_q == '0 && !any_above) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else if (timer_q == TRAVEL_LAST) begin
                    timer_d = '0;
                    if (floor_q == TOP_FLOOR) state_d = IDLE;
                    else                      floor_d = floor_q + FLOOR_W'(1);
                end
            end
            MOVE_DOWN: begin
                timer_d = timer_q + TIMER_W'(1);
                if (timer_q == '0 && any_here) begin
                    state_d = DOOR_OPEN;
                    timer_d = '0;
                end else if (timer_q == '0 && !any_below) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else if (timer_q == TRAVEL_LAST) begin
                    timer_d = '0;
                    if (floor_q == '0) state_d = IDLE;
                    else               floor_d = floor_q - FLOOR_W'(1);
                end
            end
            DOOR_OPEN: begin
                timer_d = timer_q + TIMER_W'(1);
                if (door_hit) begin
                    timer_d = '0;
                end else if (timer_q == DOOR_LAST) begin
                    state_d = IDLE;
                    timer_d = '0;
                end
            end
        endcase
    end

    // While the door is (or is about to be) open, the current floor's bit is
    // cleared every cycle, so a same-cycle request for it never survives.
    always_comb begin
        pending_d = pending_q | req_vec;
        if (state_d == DOOR_OPEN) pending_d = pending_d & ~cur_onehot;
        arrive_d  = (state_d == DOOR_OPEN) && (state_q != DOOR_OPEN);

        bus.current_floor = floor_q;
        bus.moving_up     = (state_q == MOVE_UP);
        bus.moving_down   = (state_q == MOVE_DOWN);
        bus.door_open     = (state_q == DOOR_OPEN);
        bus.arrive        = arrive_q;
        bus.pending       = pending_q;
    end
endmodule

// File: tb/tb_elevator_controller.sv
// Bench for elevator_controller: directed scenarios plus random traffic, all
// checked against a countdown-based behavioural model of the elevator.
module tb_elevator_controller;
    localparam int NF = 10;
    localparam int FW = 4;
    localparam int TT = 16;
    localparam int DT = 8;
    localparam int SW = FW + 4 + NF;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    elevator_if #(.NUM_FLOORS(NF), .FLOOR_W(FW)) bus ();

    elevator_controller #(
        .NUM_FLOORS(NF), .FLOOR_W(FW), .TRAVEL_TICKS(TT), .DOOR_TICKS(DT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural model: activity, floor, pending set, cycles left in phase.
    typedef enum int {A_IDLE, A_UP, A_DOWN, A_DOOR} act_t;
    act_t m_act = A_IDLE;
    int   m_floor = 0;
    int   m_left = 0;
    bit   m_up = 1'b1;
    bit   m_arrive = 1'b0;
    bit   m_pend [NF];

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    function automatic logic [SW-1:0] model_status();
        logic [NF-1:0] p;
        for (int f = 0; f < NF; f++) p[f] = m_pend[f];
        return {FW'(m_floor), m_act == A_UP, m_act == A_DOWN, m_act == A_DOOR, m_arrive, p};
    endfunction

    function automatic logic [SW-1:0] dut_status();
        return {bus.current_floor, bus.moving_up, bus.moving_down, bus.door_open,
                bus.arrive, bus.pending};
    endfunction

    task automatic model_tick(input bit rst, input bit rv, input int rf);
        act_t na;
        int   nf, nl;
        bit   nu, here, above, below, further;
        if (rst) begin
            m_act = A_IDLE; m_floor = 0; m_left = 0; m_up = 1'b1; m_arrive = 1'b0;
            for (int f = 0; f < NF; f++) m_pend[f] = 1'b0;
            return;
        end
        na = m_act; nf = m_floor; nl = m_left; nu = m_up;
        here = m_pend[m_floor]; above = 1'b0; below = 1'b0;
        for (int f = 0; f < NF; f++) begin
            if (m_pend[f] && f > m_floor) above = 1'b1;
            if (m_pend[f] && f < m_floor) below = 1'b1;
        end
        case (m_act)
            A_IDLE: begin
                if (here) begin na = A_DOOR; nl = DT; end
                else if (above && (m_up || !below)) begin na = A_UP; nu = 1'b1; nl = TT; end
                else if (below) begin na = A_DOWN; nu = 1'b0; nl = TT; end
            end
            A_UP, A_DOWN: begin
                further = (m_act == A_UP) ? above : below;
                if (m_left == TT && here) begin na = A_DOOR; nl = DT; end
                else if (m_left == TT && !further) na = A_IDLE;
                else begin
                    nl = m_left - 1;
                    if (nl == 0) begin
                        nl = TT;
                        nf = m_floor + ((m_act == A_UP) ? 1 : -1);
                        if (nf < 0 || nf >= NF) begin nf = m_floor; na = A_IDLE; end
                    end
                end
            end
            A_DOOR: begin
                if (rv && rf == m_floor) nl = DT;
                else if (m_left == 1) na = A_IDLE;
                else nl = m_left - 1;
            end
            default: na = A_IDLE;
        endcase
        m_arrive = (na == A_DOOR) && (m_act != A_DOOR);
        if (rv && rf < NF) m_pend[rf] = 1'b1;
        if (na == A_DOOR) m_pend[nf] = 1'b0;
        m_act = na; m_floor = nf; m_left = nl; m_up = nu;
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, settle.
    task automatic tick(input bit rst, input bit rv, input int rf);
        reset = rst;
        bus.req_valid = rv;
        bus.req_floor = FW'(rf);
        @(posedge clk);
        model_tick(rst, rv, rf);
        #1;
        if (rv && !rst) $display("req floor=%0d cycle=%0d", rf, cyc);
        cyc++;
        reset = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_floor = '0;
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b0, 0);
        tick(1'b1, 1'b0, 0);
        n_cmp++;
        if (dut_status() !== '0) begin
            $display("FAIL reset_state dut=%h expected=%h", dut_status(), {SW{1'b0}});
            n_fail++;
        end
        n_cmp++;
        if (dut_status() !== model_status()) begin
            $display("FAIL reset_model dut=%h expected=%h", dut_status(), model_status());
            n_fail++;
        end
    endtask

    // Strobe floor 2 in cycle 0; timeline fixed by travel and door ticks.
    task automatic test_single_hop();
        logic [SW-1:0] exp_s;
        logic [NF-1:0] ep;
        int k, ef;
        for (int c = 0; c <= 44; c++) begin
            tick(1'b0, c == 0, 2);
            k = c + 1;
            ef = (k < 18) ? 0 : (k < 34) ? 1 : 2;
            ep = (k <= 34) ? NF'(4) : '0;
            exp_s = {FW'(ef), (k >= 2 && k <= 34), 1'b0, (k >= 35 && k <= 42), (k == 35), ep};
            n_cmp++;
            if (dut_status() !== exp_s) begin
                $display("FAIL single_hop cycle=%0d dut=%h expected=%h", k, dut_status(), exp_s);
                n_fail++;
            end
            n_cmp++;
            if (dut_status() !== model_status()) begin
                $display("FAIL single_hop_model cycle=%0d dut=%h expected=%h", k, dut_status(), model_status());
                n_fail++;
            end
        end
    endtask

    task automatic test_scan_up();
        int arr[$];
        int downs = 0;
        tick(1'b1, 1'b0, 0);
        for (int i = 0; i < 130; i++) begin
            if (i == 0)      tick(1'b0, 1'b1, 5);
            else if (i == 6) tick(1'b0, 1'b1, 3);
            else             tick(1'b0, 1'b0, 0);
            if (bus.arrive) arr.push_back(int'(bus.current_floor));
            if (bus.moving_down) downs++;
            n_cmp++;
            if (dut_status() !== model_status()) begin
                $display("FAIL scan_up_model cycle=%0d dut=%h expected=%h", i, dut_status(), model_status());
                n_fail++;
            end
        end
        n_cmp++;
        if (arr.size() != 2 || arr[0] != 3 || arr[1] != 5 || downs != 0) begin
            $display("FAIL scan_up_order arrivals=%p downs=%0d expected arrivals=3,5 downs=0", arr, downs);
            n_fail++;
        end
    endtask

    // Floor 4, last direction up; 7 and 2 both become pending during the door phase.
    task automatic test_reverse();
        int arr[$];
        int overlaps = 0;
        tick(1'b1, 1'b0, 0);
        for (int i = 0; i < 260; i++) begin
            if (i == 0)       tick(1'b0, 1'b1, 4);
            else if (i == 70) tick(1'b0, 1'b1, 7);
            else if (i == 71) tick(1'b0, 1'b1, 2);
            else              tick(1'b0, 1'b0, 0);
            if (bus.arrive) arr.push_back(int'(bus.current_floor));
            if (int'(bus.moving_up) + int'(bus.moving_down) + int'(bus.door_open) > 1) overlaps++;
            n_cmp++;
            if (dut_status() !== model_status()) begin
                $display("FAIL reverse_model cycle=%0d dut=%h expected=%h", i, dut_status(), model_status());
                n_fail++;
            end
        end
        n_cmp++;
        if (arr.size() != 3 || arr[0] != 4 || arr[1] != 7 || arr[2] != 2 || overlaps != 0) begin
            $display("FAIL reverse_order arrivals=%p overlaps=%0d expected arrivals=4,7,2 overlaps=0", arr, overlaps);
            n_fail++;
        end
    endtask

    task automatic test_door_restart();
        int a_cyc = -100;
        int arrives = 0;
        int door_after = 0;
        bit strobed = 1'b0;
        tick(1'b1, 1'b0, 0);
        for (int k = 0; k < 100; k++) begin
            if (k == 0) tick(1'b0, 1'b1, 3);
            else if (k == a_cyc + 6) begin tick(1'b0, 1'b1, 3); strobed = 1'b1; end
            else tick(1'b0, 1'b0, 0);
            if (bus.arrive) begin arrives++; if (a_cyc < 0) a_cyc = k; end
            if (strobed && bus.door_open) door_after++;
            n_cmp++;
            if (dut_status() !== model_status()) begin
                $display("FAIL door_restart_model cycle=%0d dut=%h expected=%h", k, dut_status(), model_status());
                n_fail++;
            end
            n_cmp++;
            if (a_cyc >= 0 && bus.pending[3] !== 1'b0) begin
                $display("FAIL door_restart_pending cycle=%0d pending3=%b expected=0", k, bus.pending[3]);
                n_fail++;
            end
        end
        n_cmp++;
        if (door_after != DT || arrives != 1 || !strobed) begin
            $display("FAIL door_restart_len door_cycles=%0d arrives=%0d expected door_cycles=%0d arrives=1",
                     door_after, arrives, DT);
            n_fail++;
        end
    endtask

    // Out-of-range floors are dropped; a request at the current floor opens in two cycles.
    task automatic test_invalid_and_here();
        logic [SW-1:0] idle_s;
        int bad [3] = '{12, 10, 15};
        int moves = 0;
        idle_s = dut_status();
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, i < 3, (i < 3) ? bad[i] : 0);
            n_cmp++;
            if (dut_status() !== {FW'(3), 4'b0000, {NF{1'b0}}}) begin
                $display("FAIL invalid_req cycle=%0d dut=%h expected=%h", i, dut_status(),
                         {FW'(3), 4'b0000, {NF{1'b0}}});
                n_fail++;
            end
        end
        tick(1'b0, 1'b1, 3);
        n_cmp++;
        if (bus.arrive !== 1'b0 || bus.pending !== NF'(8)) begin
            $display("FAIL here_first arrive=%b pending=%h expected arrive=0 pending=%h", bus.arrive, bus.pending, NF'(8));
            n_fail++;
        end
        for (int i = 0; i < 12; i++) begin
            tick(1'b0, 1'b0, 0);
            if (bus.moving_up || bus.moving_down) moves++;
            n_cmp++;
            if (bus.arrive !== (i == 0) || bus.door_open !== (i < DT)) begin
                $display("FAIL here_door step=%0d arrive=%b door=%b expected arrive=%b door=%b",
                         i, bus.arrive, bus.door_open, i == 0, i < DT);
                n_fail++;
            end
        end
        n_cmp++;
        if (moves != 0 || dut_status() !== model_status() || idle_s !== {FW'(3), 4'b0000, {NF{1'b0}}}) begin
            $display("FAIL here_final moves=%0d dut=%h expected=%h start=%h", moves, dut_status(), model_status(), idle_s);
            n_fail++;
        end
    endtask

    task automatic test_reset_mid_move();
        int arr[$];
        tick(1'b1, 1'b0, 0);
        for (int i = 0; i < 42; i++) tick(1'b0, i == 0, 5);
        n_cmp++;
        if (bus.current_floor !== FW'(2) || bus.moving_up !== 1'b1) begin
            $display("FAIL mid_move_pre floor=%0d up=%b expected floor=2 up=1", bus.current_floor, bus.moving_up);
            n_fail++;
        end
        tick(1'b1, 1'b0, 0);
        n_cmp++;
        if (dut_status() !== '0) begin
            $display("FAIL mid_move_reset dut=%h expected=%h", dut_status(), {SW{1'b0}});
            n_fail++;
        end
        for (int i = 0; i < 40; i++) begin
            tick(1'b0, i == 0, 1);
            if (bus.arrive) arr.push_back(int'(bus.current_floor));
            n_cmp++;
            if (dut_status() !== model_status()) begin
                $display("FAIL mid_move_model cycle=%0d dut=%h expected=%h", i, dut_status(), model_status());
                n_fail++;
            end
        end
        n_cmp++;
        if (arr.size() != 1 || arr[0] != 1) begin
            $display("FAIL mid_move_after arrivals=%p expected arrivals=1", arr);
            n_fail++;
        end
    endtask

    task automatic test_random();
        bit rst, rv;
        int rf;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 499) == 0);
            rv  = ($urandom_range(0, 5) == 0);
            rf  = $urandom_range(0, 15);
            tick(rst, rv, rf);
            n_cmp++;
            if (dut_status() !== model_status()) begin
                $display("FAIL random cycle=%0d dut=%h expected=%h", i, dut_status(), model_status());
                n_fail++;
            end
        end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_floor = '0;
        test_reset();
        test_single_hop();
        test_scan_up();
        test_reverse();
        test_door_restart();
        test_invalid_and_here();
        test_reset_mid_move();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached at cycle %0d", cyc);
        $fatal(1, "time limit");
    end
endmodule
